// File: rtl/slice_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slice_pkg : shared width helpers and level-to-piece-count mapping    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package slice_pkg;

  // Level register width; covers MAX_LEVEL up to 7.
  localparam int c_LW = 3;

  function automatic int calc_cw(input int max_level);
    return max_level + 1;
  endfunction

  function automatic int calc_cdw(input int cooldown);
    return (cooldown < 1) ? 1 : $clog2(cooldown + 1);
  endfunction

  // Piece count for a level: 0 at level 0, otherwise 2^level.
  function automatic logic [7:0] level_to_count(input logic [c_LW-1:0] level);
    return (level == '0) ? 8'd0 : (8'd1 << level);
  endfunction

endpackage
`default_nettype wire

// File: rtl/slice_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slice_channel : one object's slice level, lockout and edge detector  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module slice_channel
  import slice_pkg::*;
#(
  parameter int MAX_LEVEL = 4,
  parameter int WRAP      = 1,
  parameter int COOLDOWN  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_slice,
  input  logic                 i_clr,
  output logic [MAX_LEVEL:0]   o_count,
  output logic                 o_full,
  output logic                 o_accept,
  output logic                 o_wrap
);

  localparam int                c_CDW     = calc_cdw(COOLDOWN);
  localparam logic [c_LW-1:0]   c_MAX     = c_LW'(MAX_LEVEL);
  localparam logic [c_CDW-1:0]  c_CD_LOAD = c_CDW'(COOLDOWN);
  localparam logic              c_WRAP    = (WRAP != 0);

  logic [c_LW-1:0]  r_level;
  logic [c_CDW-1:0] r_cd;
  logic             r_slice_q;
  logic             r_accept;
  logic             r_wrap;

  logic             w_edge;
  logic             w_full;
  logic             w_accept;
  logic [7:0]       w_count8;
  logic             w_unused_cnt;

  assign w_edge   = i_slice & ~r_slice_q;
  assign w_full   = (r_level == c_MAX);
  assign w_accept = w_edge & (r_cd == '0) & ~i_clr & ~(~c_WRAP & w_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level   <= '0;
      r_cd      <= '0;
      r_slice_q <= 1'b1;
      r_accept  <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_slice_q <= i_slice;
      r_accept  <= w_accept;
      r_wrap    <= 1'b0;
      if (i_clr) begin
        r_level <= '0;
        r_cd    <= '0;
      end else if (w_accept) begin
        // Saturate mode never accepts at max, so w_full here implies wrap.
        r_level <= w_full ? '0 : r_level + 3'd1;
        r_wrap  <= c_WRAP & w_full;
        r_cd    <= c_CD_LOAD;
      end else if (r_cd != '0) begin
        r_cd <= r_cd - 1'b1;
      end
    end
  end

  assign w_count8     = level_to_count(r_level);
  assign w_unused_cnt = ^w_count8;
  assign o_count      = w_count8[MAX_LEVEL:0];
  assign o_full       = w_full;
  assign o_accept     = r_accept;
  assign o_wrap       = r_wrap;

endmodule
`default_nettype wire

// File: rtl/slice_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slice_tracker : NUM_CH independent slice channels, packed outputs    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module slice_tracker
  import slice_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int MAX_LEVEL = 4,
  parameter int WRAP      = 1,
  parameter int COOLDOWN  = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CH-1:0]                 slice_i,
  input  logic [NUM_CH-1:0]                 clr_i,
  output logic [NUM_CH*(MAX_LEVEL+1)-1:0]   slice_num_o,
  output logic [NUM_CH-1:0]                 full_o,
  output logic [NUM_CH-1:0]                 accept_o,
  output logic [NUM_CH-1:0]                 wrap_o
);

  localparam int c_CW = calc_cw(MAX_LEVEL);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    slice_channel #(
      .MAX_LEVEL (MAX_LEVEL),
      .WRAP      (WRAP),
      .COOLDOWN  (COOLDOWN)
    ) u_channel (
      .clk      (clk),
      .rst      (rst),
      .i_slice  (slice_i[c]),
      .i_clr    (clr_i[c]),
      .o_count  (slice_num_o[c*c_CW +: c_CW]),
      .o_full   (full_o[c]),
      .o_accept (accept_o[c]),
      .o_wrap   (wrap_o[c])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_slice_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_slice_tracker : directed table-driven bench for slice_tracker     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_slice_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  slice = '0;
  logic [3:0]  clr = '0;
  logic [19:0] num;
  logic [3:0]  full, acc, wrp;

  // Saturating instance: one channel, MAX_LEVEL=2, WRAP=0.
  logic        s_slice = 1'b0;
  logic [2:0]  s_num;
  logic        s_full, s_acc, s_wrp;

  // No-lockout instance: one channel, COOLDOWN=0.
  logic        n_slice = 1'b0;
  logic [4:0]  n_num;
  logic        n_full, n_acc, n_wrp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  slice_tracker #(.NUM_CH(4), .MAX_LEVEL(4), .WRAP(1), .COOLDOWN(3)) dut (
    .clk(clk), .rst(rst), .slice_i(slice), .clr_i(clr),
    .slice_num_o(num), .full_o(full), .accept_o(acc), .wrap_o(wrp));

  slice_tracker #(.NUM_CH(1), .MAX_LEVEL(2), .WRAP(0), .COOLDOWN(3)) dut_s (
    .clk(clk), .rst(rst), .slice_i(s_slice), .clr_i(1'b0),
    .slice_num_o(s_num), .full_o(s_full), .accept_o(s_acc), .wrap_o(s_wrp));

  slice_tracker #(.NUM_CH(1), .MAX_LEVEL(4), .WRAP(1), .COOLDOWN(0)) dut_n (
    .clk(clk), .rst(rst), .slice_i(n_slice), .clr_i(1'b0),
    .slice_num_o(n_num), .full_o(n_full), .accept_o(n_acc), .wrap_o(n_wrp));

  typedef struct {
    logic [3:0]  slice;
    logic [3:0]  clr;
    int          ncyc;
    logic [19:0] num;   // final counts {ch3,ch2,ch1,ch0}
    logic [3:0]  acc;   // OR of accept_o over the row
    logic [3:0]  full;  // final full_o
    logic [3:0]  wrp;   // OR of wrap_o over the row
  } vec_t;

  vec_t tbl[$];

  function automatic logic [19:0] pk(input int c3, input int c2, input int c1, input int c0);
    logic [4:0] a3, a2, a1, a0;
    a3 = c3[4:0]; a2 = c2[4:0]; a1 = c1[4:0]; a0 = c0[4:0];
    return {a3, a2, a1, a0};
  endfunction

  task automatic add(input logic [3:0] s, input logic [3:0] c, input int n,
                     input logic [19:0] e_num, input logic [3:0] e_acc,
                     input logic [3:0] e_full, input logic [3:0] e_wrp);
    vec_t v;
    v.slice = s; v.clr = c; v.ncyc = n; v.num = e_num;
    v.acc = e_acc; v.full = e_full; v.wrp = e_wrp;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after posedge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] acc_or, wrp_or;
    int         s_acc_cnt, s_wrp_cnt, n_acc_cnt, n_wrp_cnt;
    int         s_exp[5];
    int         n_exp[5];
    s_exp = '{2, 4, 4, 4, 4};
    n_exp = '{2, 4, 8, 16, 0};

    // Ch0 walk through every level and wrap, spaced by idle cycles.
    add(4'b0000, 4'b0000, 2, pk(0,0,0,0),  4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 1, pk(0,0,0,2),  4'b0001, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 9, pk(0,0,0,2),  4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 1, pk(0,0,0,4),  4'b0001, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 9, pk(0,0,0,4),  4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 1, pk(0,0,0,8),  4'b0001, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 9, pk(0,0,0,8),  4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 1, pk(0,0,0,16), 4'b0001, 4'b0001, 4'b0000);
    add(4'b0000, 4'b0000, 9, pk(0,0,0,16), 4'b0000, 4'b0001, 4'b0000);
    add(4'b0001, 4'b0000, 1, pk(0,0,0,0),  4'b0001, 4'b0000, 4'b0001);
    add(4'b0000, 4'b0000, 3, pk(0,0,0,0),  4'b0000, 4'b0000, 4'b0000);
    // Ch1 held high: a single acceptance.
    add(4'b0010, 4'b0000, 1,  pk(0,0,2,0), 4'b0010, 4'b0000, 4'b0000);
    add(4'b0010, 4'b0000, 19, pk(0,0,2,0), 4'b0000, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 5,  pk(0,0,2,0), 4'b0000, 4'b0000, 4'b0000);
    // Ch3 lockout: edges two cycles apart, middle one dropped.
    add(4'b1000, 4'b0000, 1, pk(2,0,2,0), 4'b1000, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 1, pk(2,0,2,0), 4'b0000, 4'b0000, 4'b0000);
    add(4'b1000, 4'b0000, 1, pk(2,0,2,0), 4'b0000, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 1, pk(2,0,2,0), 4'b0000, 4'b0000, 4'b0000);
    add(4'b1000, 4'b0000, 1, pk(4,0,2,0), 4'b1000, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 5, pk(4,0,2,0), 4'b0000, 4'b0000, 4'b0000);
    // Clear beats a same-cycle edge; other channels advance together.
    add(4'b0100, 4'b0000, 1, pk(4,2,2,0), 4'b0100, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 4, pk(4,2,2,0), 4'b0000, 4'b0000, 4'b0000);
    add(4'b1101, 4'b0100, 1, pk(8,0,2,2), 4'b1001, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 4, pk(8,0,2,2), 4'b0000, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0010, 1, pk(8,0,0,2), 4'b0000, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 2, pk(8,0,0,2), 4'b0000, 4'b0000, 4'b0000);
    // Clear during lockout also releases the lockout.
    add(4'b0001, 4'b0000, 1, pk(8,0,0,4), 4'b0001, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0001, 1, pk(8,0,0,0), 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 4'b0000, 1, pk(8,0,0,2), 4'b0001, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 4, pk(8,0,0,2), 4'b0000, 4'b0000, 4'b0000);

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("reset num",   32'(num),   32'h0);
    chk("reset acc",   32'(acc),   32'h0);
    chk("reset full",  32'(full),  32'h0);
    chk("reset wrap",  32'(wrp),   32'h0);
    chk("reset s_num", 32'(s_num), 32'h0);
    chk("reset n_num", 32'(n_num), 32'h0);
    @(negedge clk) rst = 1'b0;

    foreach (tbl[i]) begin
      acc_or = '0;
      wrp_or = '0;
      for (int k = 0; k < tbl[i].ncyc; k++) begin
        @(negedge clk);
        slice = tbl[i].slice;
        clr   = tbl[i].clr;
        tick();
        acc_or |= acc;
        wrp_or |= wrp;
      end
      chk($sformatf("row%0d num", i),  32'(num),    32'(tbl[i].num));
      chk($sformatf("row%0d acc", i),  32'(acc_or), 32'(tbl[i].acc));
      chk($sformatf("row%0d full", i), 32'(full),   32'(tbl[i].full));
      chk($sformatf("row%0d wrap", i), 32'(wrp_or), 32'(tbl[i].wrp));
    end

    // Reset mid-sequence (ch3 at 8) with slice and clear active; slice held through release.
    @(negedge clk);
    rst = 1'b1; slice = 4'b0010; clr = 4'b0001;
    tick();
    chk("midrst num", 32'(num), 32'h0);
    chk("midrst acc", 32'(acc), 32'h0);
    @(negedge clk) clr = 4'b0000;
    tick();
    @(negedge clk) rst = 1'b0;
    acc_or = '0;
    repeat (3) begin
      tick();
      acc_or |= acc;
    end
    chk("held-through-reset acc", 32'(acc_or), 32'h0);
    chk("held-through-reset num", 32'(num),    32'h0);
    @(negedge clk) slice = 4'b0000;
    tick();

    // Saturate mode: five spaced edges, only two accepted.
    s_acc_cnt = 0; s_wrp_cnt = 0;
    for (int e = 0; e < 5; e++) begin
      @(negedge clk) s_slice = 1'b1;
      tick();
      s_acc_cnt += int'(s_acc); s_wrp_cnt += int'(s_wrp);
      chk($sformatf("sat edge%0d num", e), 32'(s_num), 32'(s_exp[e]));
      chk($sformatf("sat edge%0d full", e), 32'(s_full), (e >= 1) ? 32'h1 : 32'h0);
      @(negedge clk) s_slice = 1'b0;
      repeat (5) begin
        tick();
        s_acc_cnt += int'(s_acc); s_wrp_cnt += int'(s_wrp);
      end
    end
    chk("sat accept count", 32'(s_acc_cnt), 32'd2);
    chk("sat wrap count",   32'(s_wrp_cnt), 32'd0);

    // No lockout: toggling every cycle is accepted on every rising edge.
    n_acc_cnt = 0; n_wrp_cnt = 0;
    for (int e = 0; e < 5; e++) begin
      @(negedge clk) n_slice = 1'b1;
      tick();
      n_acc_cnt += int'(n_acc); n_wrp_cnt += int'(n_wrp);
      chk($sformatf("nocd edge%0d num", e), 32'(n_num), 32'(n_exp[e]));
      @(negedge clk) n_slice = 1'b0;
      tick();
      n_acc_cnt += int'(n_acc); n_wrp_cnt += int'(n_wrp);
    end
    chk("nocd accept count", 32'(n_acc_cnt), 32'd5);
    chk("nocd wrap count",   32'(n_wrp_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
